fifo_stream_reader: RTL and testbench

Read-side adapter between the BRAM-backed FIFO and any valid/ready consumer. Issues pop requests to the FIFO while it is non-empty and buffer space is available, tracks words in flight through the fixed read latency, and presents them on a stream interface with full backpressure. No word is lost or duplicated, and the consumer can stall indefinitely.

---
 rtl/fifo_rd_pkg.sv | 34 +++
 rtl/fifo_rd_obuf.sv | 75 +++++++
 rtl/fifo_stream_reader.sv | 101 ++++++++++
 tb/tb_fifo_stream_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// fifo_rd_pkg: shared widths, latency bounds and configuration check
// for the FIFO read-side stream adapter.
package fifo_rd_pkg;

    localparam int DATA_WIDTH_DEF   = 16;
    localparam int READ_LATENCY_DEF = 2;
    localparam int BUF_DEPTH_DEF    = 4;
    localparam int PKT_LEN_DEF      = 64;

    localparam int RL_MIN = 1;
    localparam int RL_MAX = 4;

    localparam int PTR_W = $clog2(BUF_DEPTH_DEF);
    localparam int CNT_W = PTR_W + 1;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_w(input int depth);
        return ptr_w(depth) + 1;
    endfunction

    // Legal latency, buffer deep enough to cover every word in
    // flight plus one, power-of-two depth so pointers wrap freely.
    function automatic bit cfg_ok(input int depth, input int lat,
                                  input int pkt);
        return (lat >= RL_MIN) && (lat <= RL_MAX) &&
               (depth >= lat + 1) &&
               ((depth & (depth - 1)) == 0) &&
               (pkt >= 1);
    endfunction

endpackage

// File: rtl/fifo_rd_obuf.sv
// fifo_rd_obuf: circular output buffer; head word is always taken
// from registered storage, never bypassed from the write port.
module fifo_rd_obuf
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int BUF_DEPTH  = BUF_DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_i,
    input  logic [DATA_WIDTH-1:0]       wdata_i,
    input  logic                        rd_i,
    output logic [DATA_WIDTH-1:0]       rdata_o,
    output logic [cnt_w(BUF_DEPTH)-1:0] count_o,
    output logic                        valid_o
);

    localparam int PW = ptr_w(BUF_DEPTH);
    localparam int CW = cnt_w(BUF_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  rd_en;

    assign valid_o = (count_q != '0);
    assign rd_en   = rd_i && valid_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Next pointers and occupancy from the write/read strobes.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (wr_i && !rd_en) begin
            count_d = count_q + CW'(1);
        end else if (!wr_i && rd_en) begin
            count_d = count_q - CW'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage; cleared so the head reads zero out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a fixed-latency FIFO into a valid/ready
// stream. Optional packet framing with macro FIFO_RD_LAST_EN.
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int READ_LATENCY = READ_LATENCY_DEF,
    parameter int BUF_DEPTH    = BUF_DEPTH_DEF,
    parameter int PKT_LEN      = PKT_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_read,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
`ifdef FIFO_RD_LAST_EN
    output logic                  m_last,
`endif
    output logic                  busy
);

    localparam int CW = cnt_w(BUF_DEPTH);

    if (!cfg_ok(BUF_DEPTH, READ_LATENCY, PKT_LEN)) begin : g_cfg_err
        $error("fifo_stream_reader: illegal BUF_DEPTH/READ_LATENCY");
    end

    logic [READ_LATENCY-1:0] fl_q, fl_d;
    logic [CW-1:0]           count;
    logic                    land;
    logic                    rd;
    int                      inflight;

    assign land = fl_q[READ_LATENCY-1];
    assign rd   = m_valid && m_ready;
    assign busy = (count != '0) || (fl_q != '0);

    // Issue rule: pop only when every outstanding word has a slot.
    // fifo_read already implies ~fifo_empty, so it is the pop itself.
    always_comb begin
        inflight = 0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            inflight = inflight + int'(fl_q[i]);
        end
        fifo_read = !rst && !fifo_empty &&
                    ((int'(count) + inflight) < BUF_DEPTH);
        fl_d = (fl_q << 1) | READ_LATENCY'(fifo_read);
    end

    // In-flight shift register; top tap marks a landing word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fl_q <= '0;
        end else begin
            fl_q <= fl_d;
        end
    end

    fifo_rd_obuf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_obuf (
        .clk     (clk),
        .rst     (rst),
        .wr_i    (land),
        .wdata_i (fifo_data),
        .rd_i    (rd),
        .rdata_o (m_data),
        .count_o (count),
        .valid_o (m_valid)
    );

`ifdef FIFO_RD_LAST_EN
    localparam int BW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

    logic [BW-1:0] beat_q, beat_d;

    assign m_last = m_valid && (beat_q == BW'(PKT_LEN - 1));

    // Beat position within the packet, advanced per handshake.
    always_comb begin
        beat_d = beat_q;
        if (rd) begin
            beat_d = (beat_q == BW'(PKT_LEN - 1)) ? '0 : beat_q + BW'(1);
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q <= '0;
        end else begin
            beat_q <= beat_d;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench with a latency-2 FIFO model
// and an expected-word queue. Honours FIFO_RD_LAST_EN when defined.
module tb_fifo_stream_reader;

    localparam int DW = 16;
    localparam int RL = 2;
    localparam int BD = 4;
    localparam int PL = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_data = '0;
    logic          fifo_read;
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic          busy;
`ifdef FIFO_RD_LAST_EN
    logic          m_last;
`endif

    fifo_stream_reader #(
        .DATA_WIDTH   (DW),
        .READ_LATENCY (RL),
        .BUF_DEPTH    (BD),
        .PKT_LEN      (PL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_read  (fifo_read),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
`ifdef FIFO_RD_LAST_EN
        .m_last     (m_last),
`endif
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // FIFO model: words written by the stimulus, popped on accepted
    // reads, data presented RL cycles after the pop.
    logic [DW-1:0] fmem [0:255];
    int            wcnt = 0;
    int            rcnt = 0;
    int            npop = 0;
    int            cyc = 0;
    int            first_pop = -1;
    logic [DW-1:0] p0 = '0;
    logic          acc;
    int            nxt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            rcnt       <= wcnt;
            fifo_empty <= 1'b1;
            p0         <= '0;
            fifo_data  <= '0;
        end else begin
            acc = fifo_read && !fifo_empty;
            nxt = rcnt + (acc ? 1 : 0);
            cyc        <= cyc + 1;
            rcnt       <= nxt;
            fifo_empty <= (nxt == wcnt);
            p0         <= acc ? fmem[rcnt] : 16'hDEAD;
            fifo_data  <= p0;
            if (acc) begin
                npop <= npop + 1;
                if (first_pop < 0) begin
                    first_pop <= cyc;
                end
            end
        end
    end

    logic ovf_seen = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            assert (!(dut.land && (int'(dut.u_obuf.count_q) >= BD)))
            else begin
                ovf_seen = 1'b1;
                $error("FAIL overflow: count=%0d limit=%0d",
                       dut.u_obuf.count_q, BD - 1);
            end
        end
    end

    int            total = 0;
    int            bad = 0;
    logic [DW-1:0] exp_q [$];
    int            nhs = 0;
    int            fv = -1;
    int            last_hs = -1;
    int            maxout = 0;
    int            outst;
    int            beat_exp = 0;
    int            h_base, p_base;
    logic [DW-1:0] e;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] req);
        total++;
        assert (obs === req)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    task automatic load(input int n, input logic [DW-1:0] base);
        for (int i = 0; i < n; i++) begin
            fmem[wcnt] = base + DW'(i);
            exp_q.push_back(base + DW'(i));
            wcnt++;
        end
    endtask

    // One cycle from a falling edge: drive ready, score, advance.
    task automatic step(input logic rdy);
        m_ready = rdy;
        #1;
        outst = npop - nhs;
        if (outst > maxout) maxout = outst;
        if (m_valid && fv < 0) fv = cyc;
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_word", 32'(m_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("data", 32'(m_data), 32'(e));
            end
`ifdef FIFO_RD_LAST_EN
            chk("m_last", 32'(m_last), 32'(beat_exp == PL - 1));
            beat_exp = (beat_exp + 1) % PL;
`endif
            nhs++;
            last_hs = cyc;
        end
        @(negedge clk);
    endtask

    initial begin
        #2 rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_fifo_read", 32'(fifo_read), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", 32'(m_data), 0);
        chk("rst_busy", 32'(busy), 0);
`ifdef FIFO_RD_LAST_EN
        chk("rst_m_last", 32'(m_last), 0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Streaming with the consumer always ready.
        load(8, 16'h0001);
        for (int i = 0; i < 20; i++) step(1'b1);
        chk("first_latency", 32'(fv - first_pop), RL + 1);
        chk("burst_span", 32'(last_hs - fv), 7);
        chk("burst_count", 32'(nhs), 8);
        chk("burst_left", 32'(exp_q.size()), 0);
        chk("burst_busy", 32'(busy), 0);

        // Stalled consumer fills the buffer, then drains.
        p_base = npop;
        h_base = nhs;
        maxout = 0;
        load(8, 16'h0001);
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            if (i % 4 == 3) begin
                #1;
                chk("stall_hold", 32'(m_data), 32'h0001);
            end
        end
        #1;
        chk("stall_pops", 32'(npop - p_base), BD);
        chk("stall_fifo_read", 32'(fifo_read), 0);
        chk("stall_m_valid", 32'(m_valid), 1);
        chk("stall_busy", 32'(busy), 1);
        chk("stall_outstanding", 32'(maxout), BD);
        for (int i = 0; i < 20; i++) step(1'b1);
        chk("drain_count", 32'(nhs - h_base), 8);
        chk("drain_left", 32'(exp_q.size()), 0);

        // Alternating ready over a long stream.
        h_base = nhs;
        maxout = 0;
        load(100, 16'h0100);
        for (int i = 0; i < 400 && (nhs - h_base) < 100; i++) begin
            step((i % 2) == 0);
        end
        chk("toggle_count", 32'(nhs - h_base), 100);
        chk("toggle_left", 32'(exp_q.size()), 0);
        chk("toggle_outstanding_le4", 32'(maxout <= BD), 1);

        // FIFO runs dry mid-stream.
        h_base = nhs;
        p_base = npop;
        load(3, 16'h0200);
        for (int i = 0; i < 10; i++) step(1'b1);
        #1;
        chk("dry_pops", 32'(npop - p_base), 3);
        chk("dry_fifo_read", 32'(fifo_read), 0);
        chk("dry_m_valid", 32'(m_valid), 0);
        load(2, 16'h0203);
        for (int i = 0; i < 30 && (nhs - h_base) < 5; i++) step(1'b1);
        #1;
        chk("dry_count", 32'(nhs - h_base), 5);
        chk("dry_total_pops", 32'(npop - p_base), 5);
        chk("dry_busy_after", 32'(busy), 0);
        @(negedge clk);

        // Reset with words buffered and in flight.
        p_base = npop;
        load(8, 16'h0300);
        for (int i = 0; i < 5; i++) step(1'b0);
        #1;
        chk("pre_rst_pops", 32'(npop - p_base), 4);
        chk("pre_rst_m_valid", 32'(m_valid), 1);
        chk("pre_rst_busy", 32'(busy), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_fifo_read", 32'(fifo_read), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_m_data", 32'(m_data), 0);
        exp_q.delete();
        beat_exp = 0;
        h_base = nhs;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) step(1'b1);
        chk("post_rst_hs", 32'(nhs - h_base), 0);
        chk("post_rst_m_valid", 32'(m_valid), 0);

`ifdef FIFO_RD_LAST_EN
        // Packet framing over two packets.
        h_base = nhs;
        load(8, 16'h0400);
        for (int i = 0; i < 40 && (nhs - h_base) < 8; i++) step(1'b1);
        chk("pkt_count", 32'(nhs - h_base), 8);
`endif

        chk("no_overflow", 32'(ovf_seen), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
